// File: rtl/rgb2raw_12.sv
// rgb2raw_12: re-mosaics RGB888 into a 12-bit Bayer RAW stream (even lines G,B / odd lines R,G), two pixels per word.
// One clock latency after the odd-column pixel; rgb_ready drops only in the odd phase while the output word is stalled.
module rgb2raw_12 #(
  parameter int LINE_LENGTH = 640,
  parameter bit INVERT_RG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  input  logic        rgb_sof,
  output logic        rgb_ready,
  output logic [23:0] raw_out,
  output logic        raw_valid,
  input  logic        raw_ready,
  output logic        raw_sof,
  output logic        raw_eol
);

  localparam int CNT_WIDTH = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(LINE_LENGTH - 1);

  logic                 ready_en;
  logic                 phase;
  logic                 line_odd;
  logic                 sof_pend;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [11:0]          hold;

  logic [7:0]           r8, g8;
  logic [11:0]          r12, g12, b12;
  logic                 accept;
  logic                 eff_phase;
  logic                 eff_odd;
  logic [CNT_WIDTH-1:0] eff_cnt;
  logic                 line_end;

  function automatic logic [11:0] expand(input logic [7:0] c);
    return {c, c[7:4]};
  endfunction

  assign r8  = INVERT_RG ? ~rgb_in[23:16] : rgb_in[23:16];
  assign g8  = INVERT_RG ? ~rgb_in[15:8]  : rgb_in[15:8];
  assign r12 = expand(r8);
  assign g12 = expand(g8);
  assign b12 = expand(rgb_in[7:0]);

  assign rgb_ready = ready_en & (~phase | ~raw_valid | raw_ready);
  assign accept    = rgb_valid & rgb_ready;

  // A start-of-frame pixel is treated as column 0 of line 0 regardless of current state.
  assign eff_phase = phase & ~rgb_sof;
  assign eff_odd   = line_odd & ~rgb_sof;
  assign eff_cnt   = rgb_sof ? '0 : word_cnt;
  assign line_end  = (eff_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      phase     <= 1'b0;
      line_odd  <= 1'b0;
      sof_pend  <= 1'b0;
      word_cnt  <= '0;
      hold      <= '0;
      raw_out   <= '0;
      raw_valid <= 1'b0;
      raw_sof   <= 1'b0;
      raw_eol   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (raw_ready) begin
        raw_valid <= 1'b0;
      end
      if (accept) begin
        if (!eff_phase) begin
          hold  <= eff_odd ? r12 : g12;
          phase <= 1'b1;
          if (rgb_sof) begin
            word_cnt <= '0;
            line_odd <= 1'b0;
            sof_pend <= 1'b1;
          end
        end else begin
          raw_out   <= {hold, (eff_odd ? g12 : b12)};
          raw_valid <= 1'b1;
          raw_sof   <= sof_pend;
          raw_eol   <= line_end;
          sof_pend  <= 1'b0;
          phase     <= 1'b0;
          if (line_end) begin
            word_cnt <= '0;
            line_odd <= ~eff_odd;
          end else begin
            word_cnt <= eff_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb2raw_12.sv
// Directed bench for rgb2raw_12: a pixel-level model pushes expected words to a queue, a negedge monitor pops and compares.
module tb_rgb2raw_12;
  localparam int LL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        rgb_valid = 1'b0;
  logic        rgb_sof = 1'b0;
  logic        rgb_ready;
  logic [23:0] raw_out;
  logic        raw_valid;
  logic        raw_ready = 1'b1;
  logic        raw_sof;
  logic        raw_eol;

  logic [23:0] i_rgb_in = '0;
  logic        i_rgb_valid = 1'b0;
  logic        i_rgb_sof = 1'b0;
  logic        i_rgb_ready;
  logic [23:0] i_raw_out;
  logic        i_raw_valid;
  logic        i_raw_sof;
  logic        i_raw_eol;

  int n_total = 0;
  int n_pass  = 0;

  logic [25:0] exp_q[$];
  int          m_col = 0;
  int          m_line = 0;
  logic        m_sofp = 1'b0;
  logic [23:0] m_prev = '0;

  rgb2raw_12 #(.LINE_LENGTH(LL), .INVERT_RG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .rgb_sof(rgb_sof),
    .rgb_ready(rgb_ready), .raw_out(raw_out), .raw_valid(raw_valid), .raw_ready(raw_ready),
    .raw_sof(raw_sof), .raw_eol(raw_eol)
  );

  rgb2raw_12 #(.LINE_LENGTH(LL), .INVERT_RG(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .rgb_in(i_rgb_in), .rgb_valid(i_rgb_valid), .rgb_sof(i_rgb_sof),
    .rgb_ready(i_rgb_ready), .raw_out(i_raw_out), .raw_valid(i_raw_valid), .raw_ready(1'b1),
    .raw_sof(i_raw_sof), .raw_eol(i_raw_eol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [11:0] x8(input logic [7:0] c);
    return {c, c[7:4]};
  endfunction

  // Model of the Bayer layout in pixel terms: column index and line number.
  task automatic model_accept(input logic [23:0] px, input logic sof);
    logic [11:0] hi, lo;
    if (sof) begin
      m_col = 0; m_line = 0; m_sofp = 1'b1;
    end
    if (m_col % 2 == 0) begin
      m_prev = px;
    end else begin
      if (m_line % 2 == 0) begin
        hi = x8(m_prev[15:8]); lo = x8(px[7:0]);
      end else begin
        hi = x8(m_prev[23:16]); lo = x8(px[15:8]);
      end
      exp_q.push_back({m_sofp, (m_col == 2*LL-1), hi, lo});
      m_sofp = 1'b0;
    end
    m_col++;
    if (m_col == 2*LL) begin
      m_col = 0; m_line++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_px(input logic [23:0] px, input logic sof, output int waits);
    bit was_odd;
    rgb_in = px; rgb_sof = sof; rgb_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!rgb_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rgb_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      rgb_valid = 1'b0;
      return;
    end
    was_odd = sof ? 1'b0 : (m_col % 2 == 1);
    model_accept(px, sof);
    @(posedge clk); #1;
    rgb_sof = 1'b0;
    if (was_odd) chk("valid_after_odd_px", {31'd0, raw_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && raw_valid && raw_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {6'd0, raw_sof, raw_eol, raw_out}, 32'hFFFF_FFFF);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("raw_word", {6'd0, raw_sof, raw_eol, raw_out}, {6'd0, e});
      end
    end
  end

  initial begin
    int w;
    logic [23:0] held;
    logic [23:0] px;
    px = 24'h102030;

    // Reset state
    #12;
    chk("rst_raw_valid", {31'd0, raw_valid}, 32'd0);
    chk("rst_raw_out", {8'd0, raw_out}, 32'd0);
    chk("rst_sof_eol", {30'd0, raw_sof, raw_eol}, 32'd0);
    chk("rst_rgb_ready", {31'd0, rgb_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, rgb_ready}, 32'd1);

    // Line 0 with a 5-clock stall while the odd pixel of word 2 waits
    send_px(px, 1'b1, w);
    for (int i = 1; i < 4; i++) send_px(px, 1'b0, w);
    raw_ready = 1'b0;
    send_px(px, 1'b0, w);
    chk("phase0_ready_in_stall", w, 0);
    held = raw_out;
    rgb_in = px; rgb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rgb_ready", {31'd0, rgb_ready}, 32'd0);
      chk("stall_raw_held", {8'd0, raw_out}, {8'd0, held});
    end
    @(posedge clk); #1;
    raw_ready = 1'b1;
    send_px(px, 1'b0, w);
    send_px(px, 1'b0, w);
    chk("resume_rate", w, 0);
    send_px(px, 1'b0, w);
    chk("resume_rate", w, 0);

    // Lines 1 (odd) and 2 (even)
    for (int i = 0; i < 4*LL; i++) send_px(px, 1'b0, w);

    // Mid-line restart on an odd-column pixel (line 3 in progress)
    send_px(24'h112233, 1'b0, w);
    send_px(24'h445566, 1'b0, w);
    send_px(24'h778899, 1'b0, w);
    send_px(24'h445566, 1'b1, w);
    send_px(24'h778899, 1'b0, w);
    for (int i = 0; i < 2*LL + 6; i++) send_px(24'hA0B0C0 + 24'(i), 1'b0, w);
    rgb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    // Reset pulse with a stalled word and a pending half-pair
    raw_ready = 1'b0;
    send_px(px, 1'b0, w);
    send_px(px, 1'b0, w);
    send_px(px, 1'b0, w);
    rgb_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, raw_valid}, 32'd1 & 32'd0);
    chk("async_rst_out", {8'd0, raw_out}, 32'd0);
    chk("async_rst_ready", {31'd0, rgb_ready}, 32'd0);
    exp_q.delete();
    m_col = 0; m_line = 0; m_sofp = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    raw_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_pulse", {31'd0, rgb_ready}, 32'd1);
    send_px(24'h0A0B0C, 1'b0, w);
    send_px(24'h0D0E0F, 1'b0, w);
    rgb_valid = 1'b0;

    // Inverting instance: R=G=0x00, B=0x80 on an even line
    i_rgb_in = 24'h000080; i_rgb_sof = 1'b1; i_rgb_valid = 1'b1;
    @(posedge clk); #1;
    i_rgb_sof = 1'b0;
    @(posedge clk); #1;
    i_rgb_valid = 1'b0;
    chk("inv_valid", {31'd0, i_raw_valid}, 32'd1);
    chk("inv_word", {8'd0, i_raw_out}, 32'h00FFF808);
    chk("inv_sof", {31'd0, i_raw_sof}, 32'd1);

    w = 0;
    while ((exp_q.size() != 0 || raw_valid) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
